// File: rtl/cmd_frame_rx.sv
// -----------------------------------------------------------------------------
// cmd_frame_rx
// Upstream command parser for the window/blind position controller.
// Assembles 5-byte frames {SYNC, ADDR, DHI, DLO, CSUM} from the UART receive
// core, validates address and 8-bit XOR checksum (CSUM = ADDR ^ DHI ^ DLO)
// and hands accepted 16-bit payloads to the motor setpoint stage.
//
// Ports:
//   clk                 in   system clock
//   rst                 in   asynchronous, active-high reset
//   rx_data[7:0]        in   byte from UART RX core, valid when rx_valid=1
//   rx_valid            in   one-cycle strobe per received byte
//   byte_data_received  out  last accepted payload {data_hi, data_lo}, held
//   WR                  out  one-cycle pulse when byte_data_received updates
//   frame_err           out  one-cycle pulse on checksum failure or timeout
//   busy                out  high while a frame is in progress
//   err_cnt[7:0]        out  saturating frame_err counter (optional)
//
// Optional feature macro: CMD_FRAME_ERR_CNT_EN adds the err_cnt output.
// -----------------------------------------------------------------------------
module cmd_frame_rx #(
  parameter logic [7:0]  DEV_ADDR    = 8'h01,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] byte_data_received,
  output logic        WR,
  output logic        frame_err,
  output logic        busy
`ifdef CMD_FRAME_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CSUM = 3'd4
  } state_t;

  // Last timer value that is still tolerated between two bytes of a frame.
  localparam logic [23:0] TIMER_LIMIT = 24'(TIMEOUT_CYC - 32'd1);

  // Frame checksum: plain 8-bit XOR over address and payload.
  function automatic logic [7:0] frame_csum(input logic [7:0] a,
                                            input logic [7:0] h,
                                            input logic [7:0] l);
    return a ^ h ^ l;
  endfunction

  // Accept frames for this node and for the broadcast address.
  function automatic logic addr_match(input logic [7:0] a);
    return (a == DEV_ADDR) || (a == 8'hFF);
  endfunction

  state_t      state_r, state_s;
  logic [23:0] timer_r, timer_s;
  logic [7:0]  addr_r, addr_s;
  logic [7:0]  hi_r, hi_s;
  logic [7:0]  lo_r, lo_s;
  logic [15:0] data_r, data_s;
  logic        wr_r, wr_s;
  logic        err_r, err_s;
  logic        busy_r;

  // Next-state, shadow-register and pulse decode for the frame FSM.
  always_comb begin
    state_s = state_r;
    timer_s = timer_r;
    addr_s  = addr_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    data_s  = data_r;
    wr_s    = 1'b0;
    err_s   = 1'b0;
    if (rx_valid) begin
      // A byte always wins over a timeout hitting in the same cycle.
      timer_s = 24'd0;
      case (state_r)
        IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_s = ADDR;
          end else begin
            state_s = IDLE;
          end
        end
        ADDR: begin
          addr_s  = rx_data;
          state_s = DHI;
        end
        DHI: begin
          hi_s    = rx_data;
          state_s = DLO;
        end
        DLO: begin
          lo_s    = rx_data;
          state_s = CSUM;
        end
        CSUM: begin
          state_s = IDLE;
          if (rx_data == frame_csum(addr_r, hi_r, lo_r)) begin
            if (addr_match(addr_r)) begin
              data_s = {hi_r, lo_r};
              wr_s   = 1'b1;
            end else begin
              // Well-formed frame for another node: drop quietly.
              data_s = data_r;
            end
          end else begin
            err_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else if (state_r == IDLE) begin
      timer_s = 24'd0;
    end else if (timer_r >= TIMER_LIMIT) begin
      // Stale frame: abandon it and report.
      state_s = IDLE;
      timer_s = 24'd0;
      err_s   = 1'b1;
    end else begin
      timer_s = timer_r + 24'd1;
    end
  end

  // State, timer, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      timer_r <= 24'd0;
      addr_r  <= 8'h00;
      hi_r    <= 8'h00;
      lo_r    <= 8'h00;
      data_r  <= 16'h0000;
      wr_r    <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      timer_r <= timer_s;
      addr_r  <= addr_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      data_r  <= data_s;
      wr_r    <= wr_s;
      err_r   <= err_s;
      // Registered from the next state so busy tracks state != IDLE exactly.
      busy_r  <= (state_s != IDLE);
    end
  end

  assign byte_data_received = data_r;
  assign WR                 = wr_r;
  assign frame_err          = err_r;
  assign busy               = busy_r;

`ifdef CMD_FRAME_ERR_CNT_EN
  logic [7:0] err_cnt_r;

  // Saturating count of frame_err pulses; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= 8'h00;
    end else if (err_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_cmd_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_cmd_frame_rx
// Directed bench for cmd_frame_rx with a frame-level reference model and a
// per-cycle compare process, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_cmd_frame_rx;

  localparam logic [7:0]  DEV  = 8'h01;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned TO   = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] byte_data_received;
  logic        WR;
  logic        frame_err;
  logic        busy;
`ifdef CMD_FRAME_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cmd_frame_rx #(
    .DEV_ADDR   (DEV),
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .byte_data_received(byte_data_received),
    .WR                (WR),
    .frame_err         (frame_err),
    .busy              (busy)
`ifdef CMD_FRAME_ERR_CNT_EN
    ,
    .err_cnt           (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  fb [0:4];
  int          nbytes;
  int          gap;
  logic [15:0] exp_data;
  logic        exp_wr;
  logic        exp_err;
  logic [7:0]  exp_cnt;
  logic        exp_busy;

  assign exp_busy = (nbytes != 0);

  // Collect bytes of a frame; judge it when the fifth arrives.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nbytes   <= 0;
      gap      <= 0;
      exp_data <= 16'h0000;
      exp_wr   <= 1'b0;
      exp_err  <= 1'b0;
      exp_cnt  <= 8'h00;
    end else begin
      exp_wr  <= 1'b0;
      exp_err <= 1'b0;
      if (rx_valid) begin
        gap <= 0;
        if (nbytes == 0) begin
          if (rx_data == SYNC) nbytes <= 1;
        end else if (nbytes < 4) begin
          fb[nbytes] <= rx_data;
          nbytes     <= nbytes + 1;
        end else begin
          nbytes <= 0;
          if ((fb[1] ^ fb[2] ^ fb[3]) == rx_data) begin
            if (fb[1] == DEV || fb[1] == 8'hFF) begin
              exp_data <= {fb[2], fb[3]};
              exp_wr   <= 1'b1;
            end
          end else begin
            exp_err <= 1'b1;
            if (exp_cnt != 8'hFF) exp_cnt <= exp_cnt + 8'd1;
          end
        end
      end else if (nbytes != 0) begin
        if (gap == TO - 1) begin
          nbytes  <= 0;
          gap     <= 0;
          exp_err <= 1'b1;
          if (exp_cnt != 8'hFF) exp_cnt <= exp_cnt + 8'd1;
        end else begin
          gap <= gap + 1;
        end
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    chk("cyc_data", {16'h0, byte_data_received}, {16'h0, exp_data});
    chk("cyc_wr", {31'h0, WR}, {31'h0, exp_wr});
    chk("cyc_err", {31'h0, frame_err}, {31'h0, exp_err});
    chk("cyc_busy", {31'h0, busy}, {31'h0, exp_busy});
`ifdef CMD_FRAME_ERR_CNT_EN
    chk("cyc_cnt", {24'h0, err_cnt}, {24'h0, exp_cnt});
`endif
  end

  // ---------------- stimulus ----------------
  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    put(b0); put(b1); put(b2); put(b3); put(b4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_data", {16'h0, byte_data_received}, 32'h0);
    chk("rst_wr", {31'h0, WR}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    idle(2);

    // Basic accepted frame
    frame(8'hA5, 8'h01, 8'h08, 8'hC8, 8'hC1);
    idle(1);
    chk("t1_wr", {31'h0, WR}, 32'h1);
    chk("t1_data", {16'h0, byte_data_received}, 32'h08C8);
    idle(1);
    chk("t1_wr_off", {31'h0, WR}, 32'h0);
    chk("t1_busy", {31'h0, busy}, 32'h0);

    // Broadcast, then foreign address
    frame(8'hA5, 8'hFF, 8'h00, 8'h40, 8'hBF);
    idle(1);
    chk("t2_wr", {31'h0, WR}, 32'h1);
    chk("t2_data", {16'h0, byte_data_received}, 32'h0040);
    frame(8'hA5, 8'h02, 8'h00, 8'h10, 8'h12);
    idle(1);
    chk("t2f_wr", {31'h0, WR}, 32'h0);
    chk("t2f_err", {31'h0, frame_err}, 32'h0);
    chk("t2f_data", {16'h0, byte_data_received}, 32'h0040);

    // Bad checksum
    frame(8'hA5, 8'h01, 8'h00, 8'h10, 8'h00);
    idle(1);
    chk("t3_err", {31'h0, frame_err}, 32'h1);
    chk("t3_wr", {31'h0, WR}, 32'h0);
    chk("t3_data", {16'h0, byte_data_received}, 32'h0040);
`ifdef CMD_FRAME_ERR_CNT_EN
    chk("t3_cnt", {24'h0, err_cnt}, 32'h1);
`endif

    // Inter-byte timeout
    put(8'hA5); put(8'h01);
    idle(1);
    for (i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (frame_err) break;
    end
    chk("t4_to_cycles", i, 16);
    chk("t4_busy", {31'h0, busy}, 32'h0);
    idle(4);
    frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
    idle(1);
    chk("t4_wr", {31'h0, WR}, 32'h1);
    chk("t4_data", {16'h0, byte_data_received}, 32'h1234);
    idle(2);

    // Leading garbage, SYNC values used as data
    put(8'h00);
    idle(1);
    chk("t5_noerr", {31'h0, frame_err}, 32'h0);
    frame(8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01);
    idle(1);
    chk("t5_wr", {31'h0, WR}, 32'h1);
    chk("t5_data", {16'h0, byte_data_received}, 32'hA5A5);

    // Back-to-back frames, no dead cycle
    frame(8'hA5, 8'hFF, 8'h11, 8'h22, 8'hCC);
    frame(8'hA5, 8'h01, 8'h33, 8'h44, 8'h76);
    idle(1);
    chk("t6_data", {16'h0, byte_data_received}, 32'h3344);
    idle(2);

    // Byte arrives in the very cycle the timer hits its limit
    put(8'hA5); put(8'h01);
    idle(15);
    put(8'h56); put(8'h78); put(8'h2F);
    idle(1);
    chk("t7_wr", {31'h0, WR}, 32'h1);
    chk("t7_data", {16'h0, byte_data_received}, 32'h5678);
    idle(2);

    // Asynchronous reset mid-frame
    put(8'hA5); put(8'h01); put(8'h12);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t8_data", {16'h0, byte_data_received}, 32'h0);
    chk("t8_busy", {31'h0, busy}, 32'h0);
    chk("t8_wr", {31'h0, WR}, 32'h0);
    chk("t8_err", {31'h0, frame_err}, 32'h0);
`ifdef CMD_FRAME_ERR_CNT_EN
    chk("t8_cnt", {24'h0, err_cnt}, 32'h0);
`endif
    @(negedge clk);
    rx_valid = 1'b0;
    rst      = 1'b0;
    idle(1);
    frame(8'hA5, 8'h01, 8'h00, 8'h05, 8'h04);
    idle(1);
    chk("t8_wr_after", {31'h0, WR}, 32'h1);
    chk("t8_data_after", {16'h0, byte_data_received}, 32'h0005);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
